// File: rtl/pic_mem_pkg.sv
// Shared definitions for the PIC_RISC data-memory access path:
// op encoding, controller state type and datapath widths.
package pic_mem_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;

  localparam logic [2:0] OP_READ  = 3'd0;
  localparam logic [2:0] OP_WRITE = 3'd1;
  localparam logic [2:0] OP_INC   = 3'd2;
  localparam logic [2:0] OP_DEC   = 3'd3;
  localparam logic [2:0] OP_COMF  = 3'd4;
  localparam logic [2:0] OP_SWAPF = 3'd5;
  localparam logic [2:0] OP_BCF   = 3'd6;
  localparam logic [2:0] OP_BSF   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/data_mem_rmw_alu.sv
// Combinational modify stage for file-register read-modify-write ops.
// z_upd marks the ops that are allowed to change the Z flag.
module data_mem_rmw_alu
  import pic_mem_pkg::*;
(
  input  logic [2:0]        op,
  input  logic [2:0]        bit_sel,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] r,
  output logic              z_upd,
  output logic              z_val
);

  always_comb begin
    r     = d;
    z_upd = 1'b0;
    case (op)
      OP_READ:  z_upd = 1'b1;
      OP_WRITE: r = d;
      OP_INC:   begin r = d + 8'd1; z_upd = 1'b1; end
      OP_DEC:   begin r = d - 8'd1; z_upd = 1'b1; end
      OP_COMF:  begin r = ~d;       z_upd = 1'b1; end
      OP_SWAPF: r = {d[3:0], d[7:4]};
      OP_BCF:   r[bit_sel] = 1'b0;
      OP_BSF:   r[bit_sel] = 1'b1;
      default:  r = d;
    endcase
  end

  assign z_val = (r == '0);

endmodule

// File: rtl/data_mem_access_ctrl.sv
// Sequences one read / write / read-modify-write on the Data_Memory port.
// All outputs are registered, so an async reset clears them without a clock.
//   state   | meaning
//   IDLE    | waiting for req; captures the op on acceptance
//   RD      | address presented, read wait counting down, then sample
//   WR      | mem_rd_wr low for exactly one edge (the write edge)
//   DONE    | raise done, drop busy, return to IDLE
module data_mem_access_ctrl
  import pic_mem_pkg::*;
#(
  parameter int READ_WAIT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [2:0]        bit_sel,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              z,
  output logic              mem_rd_wr,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_bus
);

  state_e            state_q;
  logic [2:0]        op_q;
  logic [2:0]        bit_sel_q;
  logic              wait_q;
  logic              busy_q;
  logic              done_q;
  logic [DATA_W-1:0] rdata_q;
  logic              z_q;
  logic              mem_rd_wr_q;
  logic [ADDR_W-1:0] mem_address_q;
  logic [DATA_W-1:0] mem_data_in_q;

  logic [DATA_W-1:0] alu_r;
  logic              alu_z_upd;
  logic              alu_z_val;

  data_mem_rmw_alu u_alu (
    .op      (op_q),
    .bit_sel (bit_sel_q),
    .d       (mem_data_bus),
    .r       (alu_r),
    .z_upd   (alu_z_upd),
    .z_val   (alu_z_val)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      op_q          <= OP_READ;
      bit_sel_q     <= 3'd0;
      wait_q        <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      rdata_q       <= '0;
      z_q           <= 1'b0;
      mem_rd_wr_q   <= 1'b1;
      mem_address_q <= '0;
      mem_data_in_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req) begin
            op_q          <= op;
            bit_sel_q     <= bit_sel;
            mem_address_q <= addr;
            busy_q        <= 1'b1;
            wait_q        <= 1'(READ_WAIT);
            if (op == OP_WRITE) begin
              mem_rd_wr_q   <= 1'b0;
              mem_data_in_q <= wdata;
              state_q       <= ST_WR;
            end else begin
              mem_rd_wr_q <= 1'b1;
              state_q     <= ST_RD;
            end
          end
        end
        ST_RD: begin
          if (wait_q != 1'b0) begin
            wait_q <= 1'b0;
          end else begin
            rdata_q <= alu_r;
            if (alu_z_upd) z_q <= alu_z_val;
            if (op_q == OP_READ) begin
              state_q <= ST_DONE;
            end else begin
              mem_rd_wr_q   <= 1'b0;
              mem_data_in_q <= alu_r;
              state_q       <= ST_WR;
            end
          end
        end
        ST_WR: begin
          mem_rd_wr_q <= 1'b1;
          state_q     <= ST_DONE;
        end
        ST_DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign rdata       = rdata_q;
  assign z           = z_q;
  assign mem_rd_wr   = mem_rd_wr_q;
  assign mem_address = mem_address_q;
  assign mem_data_in = mem_data_in_q;

endmodule
